// File: rtl/serial_tx_scheduler.sv
// Shares one serial transmitter between the processor PIO (req0) and the echo path (req1).
// Define SERIAL_TX_SCHED_ECHO_EN to arbitrate requester 1; otherwise only requester 0 is served.
module serial_tx_scheduler #(
  parameter int DATA_W    = 10,
  parameter int TIMEOUT   = 4096,
  parameter int TIMEOUT_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              tx_enable,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  input  logic              tx_sent,
  output logic              grant_id,
  output logic              busy,
  output logic              timeout_err,
  output logic [15:0]       char_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_SENT
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_W-1:0]     hold;
  logic [TIMEOUT_W-1:0]  tmo_count;
  logic                  grant;
  logic                  grant_valid;
  logic                  transfer;
  logic                  at_limit;
  logic                  complete;
  logic                  abort;

`ifdef SERIAL_TX_SCHED_ECHO_EN
  logic rr;

  // Contention resolved by the round-robin pointer; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = rr;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign grant_valid = req0_valid | req1_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr       <= 1'b0;
      grant_id <= 1'b0;
    end else begin
      if (transfer) begin
        grant_id <= grant;
      end
      if (complete || abort) begin
        rr <= ~grant_id;
      end
    end
  end
`else
  logic unused_req1;

  assign grant       = 1'b0;
  assign grant_valid = req0_valid;
  assign grant_id    = 1'b0;
  assign unused_req1 = req1_valid;
`endif

  assign req0_ready = (state == IDLE) && grant_valid && !grant;
  assign req1_ready = (state == IDLE) && grant_valid && grant;
  assign transfer   = req0_ready | req1_ready;
  assign at_limit   = (tmo_count == TIMEOUT_W'(TIMEOUT - 1));

  // A completion or load event in the final counted cycle takes priority over the abort.
  always_comb begin
    state_next = state;
    complete   = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: begin
        if (transfer) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (tx_load && tx_sent) begin
          state_next = IDLE;
          complete   = 1'b1;
        end else if (tx_load) begin
          state_next = WAIT_SENT;
        end else if (at_limit) begin
          state_next = IDLE;
          abort      = 1'b1;
        end
      end
      WAIT_SENT: begin
        if (tx_sent) begin
          state_next = IDLE;
          complete   = 1'b1;
        end else if (at_limit) begin
          state_next = IDLE;
          abort      = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hold        <= '0;
      tmo_count   <= '0;
      timeout_err <= 1'b0;
      char_count  <= '0;
    end else begin
      state       <= state_next;
      timeout_err <= abort;
      if (transfer) begin
        hold <= grant ? req1_data : req0_data;
      end
      // Counter restarts on every state change so each phase gets its own budget.
      if ((state_next != state) || (state == IDLE)) begin
        tmo_count <= '0;
      end else begin
        tmo_count <= tmo_count + 1'b1;
      end
      if (complete) begin
        char_count <= char_count + 16'd1;
      end
    end
  end

  assign tx_enable = (state == LOAD);
  assign busy      = (state != IDLE);
  assign tx_data   = hold;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Randomized transaction-level bench for serial_tx_scheduler, checked against a grant/count model.
module tb_serial_tx_scheduler;

  localparam int DATA_W    = 10;
  localparam int TIMEOUT   = 16;
  localparam int TIMEOUT_W = 5;
`ifdef SERIAL_TX_SCHED_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              tx_enable;
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_sent;
  logic              grant_id;
  logic              busy;
  logic              timeout_err;
  logic [15:0]       char_count;

  int checks = 0;
  int errors = 0;
  bit model_rr;
  int model_count;

  serial_tx_scheduler #(
    .DATA_W(DATA_W),
    .TIMEOUT(TIMEOUT),
    .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req0_valid(req0_valid),
    .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data(req1_data),
    .req1_ready(req1_ready),
    .tx_enable(tx_enable),
    .tx_data(tx_data),
    .tx_load(tx_load),
    .tx_sent(tx_sent),
    .grant_id(grant_id),
    .busy(busy),
    .timeout_err(timeout_err),
    .char_count(char_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Who should win: without the echo path only requester 0 exists.
  function automatic bit modelGrant(input bit v0, input bit v1, input bit rr);
    if (!ECHO) return 1'b0;
    if (v0 && v1) return rr;
    return v1;
  endfunction

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_enable"}, tx_enable, 0);
    checkOutput({tag, "_count"}, char_count, model_count);
  endtask

  task automatic finishChar(input bit completed, input bit g);
    if (completed) model_count = (model_count + 1) & 16'hFFFF;
    model_rr = ECHO ? ~g : 1'b0;
    checkIdle("end");
    checkOutput("end_timeout_err", timeout_err, !completed);
  endtask

  // pattern: 0=req0 only, 1=req1 only, 2=both. mode: 0 normal, 1 load+sent together,
  // 2 timeout in LOAD, 3 timeout in WAIT_SENT, 4 reset in WAIT_SENT.
  task automatic applyStimulus(input int pattern, input logic [DATA_W-1:0] d0,
                               input logic [DATA_W-1:0] d1, input int mode);
    bit v0, v1, accepted, g;
    logic [DATA_W-1:0] exp_data;
    int stall;
    v0 = (pattern != 1);
    v1 = (pattern != 0);
    req0_valid = v0;
    req1_valid = v1;
    req0_data  = d0;
    req1_data  = d1;
    #1;
    accepted = v0 || (ECHO && v1);
    g = modelGrant(v0, v1, model_rr);
    checkOutput("req0_ready", req0_ready, accepted && !g);
    checkOutput("req1_ready", req1_ready, accepted && g);
    if (!accepted) begin
      tick();
      checkOutput("busy_no_grant", busy, 0);
      v0 = 1'b1;
      req0_valid = 1'b1;
      #1;
      g = modelGrant(v0, v1, model_rr);
      checkOutput("req0_ready_late", req0_ready, !g);
      checkOutput("req1_ready_late", req1_ready, g);
    end
    exp_data = g ? d1 : d0;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = DATA_W'($urandom);
    req1_data  = DATA_W'($urandom);
    checkOutput("start_enable", tx_enable, 1);
    checkOutput("start_busy", busy, 1);
    checkOutput("start_tx_data", tx_data, exp_data);
    checkOutput("start_grant_id", grant_id, g);
    checkOutput("start_ready0", req0_ready, 0);

    case (mode)
      0: begin
        stall = $urandom_range(0, 4);
        for (int i = 0; i < stall; i++) begin
          tx_sent = 1'($urandom_range(0, 1));
          tick();
          checkOutput("load_enable", tx_enable, 1);
        end
        tx_sent = 1'b0;
        tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
        checkOutput("wait_enable", tx_enable, 0);
        checkOutput("wait_busy", busy, 1);
        stall = $urandom_range(0, 6);
        for (int i = 0; i < stall; i++) begin
          tx_load = 1'($urandom_range(0, 1));
          tick();
          checkOutput("wait_busy_hold", busy, 1);
          checkOutput("wait_tx_data", tx_data, exp_data);
        end
        tx_load = 1'b0;
        tx_sent = 1'b1;
        tick();
        tx_sent = 1'b0;
        finishChar(1'b1, g);
      end
      1: begin
        tx_load = 1'b1;
        tx_sent = 1'b1;
        tick();
        tx_load = 1'b0;
        tx_sent = 1'b0;
        finishChar(1'b1, g);
      end
      2, 3: begin
        if (mode == 3) begin
          tx_load = 1'b1;
          tick();
          tx_load = 1'b0;
        end
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        checkOutput("tmo_busy_last", busy, 1);
        checkOutput("tmo_err_early", timeout_err, 0);
        tick();
        finishChar(1'b0, g);
        tick();
        checkOutput("tmo_err_pulse", timeout_err, 0);
      end
      default: begin
        tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_count = 0;
        model_rr = 1'b0;
        checkIdle("rst");
        checkOutput("rst_tx_data", tx_data, 0);
        checkOutput("rst_grant_id", grant_id, 0);
        checkOutput("rst_timeout_err", timeout_err, 0);
        tx_sent = 1'b1;
        tick();
        tx_sent = 1'b0;
        checkIdle("rst_late_sent");
      end
    endcase

    tx_sent = 1'b1;
    tick();
    tx_sent = 1'b0;
    checkIdle("stray_sent");
  endtask

  initial begin
    int mode;
    reset      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    tx_load    = 1'b0;
    tx_sent    = 1'b0;
    model_rr   = 1'b0;
    model_count = 0;
    tick();
    tick();
    checkIdle("reset");
    checkOutput("reset_tx_data", tx_data, 0);
    checkOutput("reset_grant_id", grant_id, 0);
    checkOutput("reset_timeout_err", timeout_err, 0);
    checkOutput("reset_ready0", req0_ready, 0);
    checkOutput("reset_ready1", req1_ready, 0);
    reset = 1'b0;

    applyStimulus(0, 10'h041, 10'h000, 0);
    for (int i = 0; i < 4; i++) applyStimulus(2, 10'h0AA, 10'h155, 0);
    applyStimulus(2, 10'h0AA, 10'h155, 2);
    applyStimulus(2, 10'h0AA, 10'h155, 0);
    applyStimulus(2, 10'h123, 10'h321, 3);
    applyStimulus(0, 10'h3FF, 10'h001, 1);
    applyStimulus(2, 10'h0F0, 10'h00F, 4);
    applyStimulus(1, 10'h111, 10'h222, 0);

    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 9);
      if (mode > 4) mode = mode - 5;
      if (mode == 4 && $urandom_range(0, 3) != 0) mode = 0;
      applyStimulus($urandom_range(0, 2), DATA_W'($urandom), DATA_W'($urandom), mode);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
